// File: rtl/joy_tx.sv
// Joypad transmitter for input playback: answers $4016/$4017 reads with serial
// button bits drawn from a small frame FIFO loaded through two mapper registers.
module joy_tx #(
  parameter logic [15:0] REG_JTX_DATA = 16'h40F4,
  parameter logic [15:0] REG_JTX_CTRL = 16'h40F5,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  OPEN_BUS     = 8'h40
) (
  input  logic        sys_rst,
  input  logic        m2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dat,
  output logic [7:0]  jtx_do,
  output logic        jtx_oe
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(FIFO_DEPTH);
  localparam logic [15:0] PAD0_ADDR = 16'h4016;
  localparam logic [15:0] PAD1_ADDR = 16'h4017;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             phase_q, phase_d;
  logic [7:0]       staging_q, staging_d;
  logic             en_q, en_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             load_q, load_d;
  logic [15:0]      hold_frame_q, hold_frame_d;
  logic [7:0]       sr0_q, sr0_d;
  logic [7:0]       sr1_q, sr1_d;
  logic [15:0]      mem_q [FIFO_DEPTH];

  logic        pad0_sel, pad1_sel, data_sel, ctrl_sel;
  logic        cpu_wr, fifo_empty, fifo_full;
  logic        flush, strobe_fall, pop, push_req, push;
  logic [15:0] head;
  logic        pad_bit;
  logic [7:0]  status;

  assign pad0_sel   = (cpu_addr == PAD0_ADDR);
  assign pad1_sel   = (cpu_addr == PAD1_ADDR);
  assign data_sel   = (cpu_addr == REG_JTX_DATA);
  assign ctrl_sel   = (cpu_addr == REG_JTX_CTRL);
  assign cpu_wr     = ~cpu_rw;
  assign fifo_empty = (count_q == 4'd0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    phase_d      = phase_q;
    staging_d    = staging_q;
    en_d         = en_q;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    load_d       = load_q;
    hold_frame_d = hold_frame_q;
    sr0_d        = sr0_q;
    sr1_d        = sr1_q;

    flush       = cpu_wr & ctrl_sel & cpu_dat[6];
    strobe_fall = cpu_wr & pad0_sel & load_q & ~cpu_dat[0];
    pop         = strobe_fall & en_q & ~fifo_empty & ~flush;
    push_req    = cpu_wr & data_sel & phase_q;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push        = push_req & (~fifo_full | pop);

    if (cpu_wr & data_sel) begin
      phase_d = ~phase_q;
      if (!phase_q) staging_d = cpu_dat;
    end
    if (push_req & ~push) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      hold_frame_d = head;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (strobe_fall & en_q & fifo_empty & ~flush) udf_d = 1'b1;

    if (cpu_wr & pad0_sel) load_d = cpu_dat[0];
    if (strobe_fall) begin
      sr0_d = pop ? head[7:0]  : hold_frame_q[7:0];
      sr1_d = pop ? head[15:8] : hold_frame_q[15:8];
    end
    // Reads with the strobe low consume one bit and backfill with 1s.
    if (cpu_rw & ~load_q & pad0_sel) sr0_d = {sr0_q[6:0], 1'b1};
    if (cpu_rw & ~load_q & pad1_sel) sr1_d = {sr1_q[6:0], 1'b1};

    if (cpu_wr & ctrl_sel) en_d = cpu_dat[7];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
      phase_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(negedge m2 or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 4'd0;
      phase_q      <= 1'b0;
      staging_q    <= 8'h00;
      en_q         <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      load_q       <= 1'b0;
      hold_frame_q <= 16'hFFFF;
      sr0_q        <= 8'hFF;
      sr1_q        <= 8'hFF;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      staging_q    <= staging_d;
      en_q         <= en_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      load_q       <= load_d;
      hold_frame_q <= hold_frame_d;
      sr0_q        <= sr0_d;
      sr1_q        <= sr1_d;
    end
  end

  // Frame storage needs no reset; contents are invalid whenever count is zero.
  always_ff @(negedge m2) begin
    if (push) mem_q[wr_ptr_q] <= {cpu_dat, staging_q};
  end

  always_comb begin
    pad_bit = 1'b1;
    if (pad0_sel)
      pad_bit = load_q ? (fifo_empty ? hold_frame_q[7] : head[7]) : sr0_q[7];
    else if (pad1_sel)
      pad_bit = load_q ? (fifo_empty ? hold_frame_q[15] : head[15]) : sr1_q[7];
  end

  assign status = {en_q, ovf_q, udf_q, 1'b0, count_q};
  assign jtx_do = ctrl_sel ? status : {OPEN_BUS[7:1], pad_bit};
  assign jtx_oe = cpu_rw & ((en_q & (pad0_sel | pad1_sel)) | ctrl_sel);

endmodule

// File: tb/tb_joy_tx.sv
// Self-checking bench for joy_tx: directed scenarios followed by a random
// bus-operation mix, all compared against a queue-based behavioural model.
module tb_joy_tx;

   localparam logic [15:0] A_DATA = 16'h40F4;
   localparam logic [15:0] A_CTRL = 16'h40F5;
   localparam logic [15:0] A_P0   = 16'h4016;
   localparam logic [15:0] A_P1   = 16'h4017;
   localparam logic [15:0] A_IDLE = 16'h8000;

   logic        sys_rst;
   logic        m2;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_dat;
   logic [7:0]  jtx_do;
   logic        jtx_oe;

   int checkCount = 0;
   int failCount  = 0;

   // Behavioural model state: frames are kept in a plain queue and each port
   // remembers the byte it latched at the last strobe fall plus how many bits
   // have been read out of it since.
   logic [15:0] modelFifo[$];
   logic [15:0] modelHold;
   logic        modelEn, modelOvf, modelUdf, modelLoad, modelPhase;
   logic [7:0]  modelStaging;
   logic [7:0]  modelByte0, modelByte1;
   int          modelIdx0, modelIdx1;

   joy_tx dut (
      .sys_rst  (sys_rst),
      .m2       (m2),
      .cpu_addr (cpu_addr),
      .cpu_rw   (cpu_rw),
      .cpu_dat  (cpu_dat),
      .jtx_do   (jtx_do),
      .jtx_oe   (jtx_oe)
   );

   // Free-running CPU phase-2 clock; the design acts on its falling edge.
   initial begin
      m2 = 1'b0;
      forever #5 m2 = ~m2;
   end

   // Put the model back into its power-on state.
   function automatic void modelReset();
      modelFifo.delete();
      modelHold    = 16'hFFFF;
      modelEn      = 1'b0;
      modelOvf     = 1'b0;
      modelUdf     = 1'b0;
      modelLoad    = 1'b0;
      modelPhase   = 1'b0;
      modelStaging = 8'h00;
      modelByte0   = 8'hFF;
      modelByte1   = 8'hFF;
      modelIdx0    = 0;
      modelIdx1    = 0;
   endfunction

   // Apply the effect of one CPU write to the model.
   function automatic void modelWrite(input logic [15:0] a, input logic [7:0] d);
      if (a == A_DATA) begin
         if (!modelPhase) modelStaging = d;
         else if (modelFifo.size() < 8) modelFifo.push_back({d, modelStaging});
         else modelOvf = 1'b1;
         modelPhase = ~modelPhase;
      end else if (a == A_CTRL) begin
         modelEn = d[7];
         if (d[6]) begin
            modelFifo.delete();
            modelPhase = 1'b0;
            modelOvf   = 1'b0;
            modelUdf   = 1'b0;
         end
      end else if (a == A_P0) begin
         if (modelLoad && !d[0]) begin
            if (modelEn) begin
               if (modelFifo.size() != 0) modelHold = modelFifo.pop_front();
               else modelUdf = 1'b1;
            end
            modelByte0 = modelHold[7:0];
            modelByte1 = modelHold[15:8];
            modelIdx0  = 0;
            modelIdx1  = 0;
         end
         modelLoad = d[0];
      end
   endfunction

   // Expected {oe, do} for a read, advancing the per-port bit position.
   function automatic logic [8:0] modelRead(input logic [15:0] a);
      logic       b;
      logic [7:0] pbyte;
      int         idx;
      if (a == A_CTRL)
         return {1'b1, modelEn, modelOvf, modelUdf, 1'b0, 4'(modelFifo.size())};
      if (a != A_P0 && a != A_P1)
         return 9'h000;
      if (modelLoad) begin
         if (modelFifo.size() != 0) b = a[0] ? modelFifo[0][15] : modelFifo[0][7];
         else b = a[0] ? modelHold[15] : modelHold[7];
      end else begin
         pbyte = a[0] ? modelByte1 : modelByte0;
         idx   = a[0] ? modelIdx1 : modelIdx0;
         b     = (idx < 8) ? pbyte[7 - idx] : 1'b1;
         if (a[0]) modelIdx1 = modelIdx1 + 1;
         else modelIdx0 = modelIdx0 + 1;
      end
      return {modelEn, 7'h20, b};
   endfunction

   // Drive one bus cycle and capture {oe, do} mid-cycle, well clear of negedge.
   task automatic applyStimulus(input logic [15:0] a, input logic rw,
                                input logic [7:0] d, output logic [8:0] obs);
      cpu_addr = a;
      cpu_rw   = rw;
      cpu_dat  = d;
      @(posedge m2);
      #1;
      obs = {jtx_oe, jtx_do};
      @(negedge m2);
      #1;
      cpu_addr = A_IDLE;
      cpu_rw   = 1'b1;
      cpu_dat  = 8'h00;
   endtask

   // One comparison point: count it and report any disagreement.
   task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus write that keeps the model in step.
   task automatic doWrite(input logic [15:0] a, input logic [7:0] d);
      logic [8:0] obs;
      applyStimulus(a, 1'b0, d, obs);
      modelWrite(a, d);
   endtask

   // Bus read checked against the model; unrelated addresses check oe only.
   task automatic doRead(input logic [15:0] a, input string tag);
      logic [8:0] obs, exp;
      exp = modelRead(a);
      applyStimulus(a, 1'b1, 8'h00, obs);
      if (a == A_CTRL || a == A_P0 || a == A_P1) checkOutput(tag, obs, exp);
      else checkOutput(tag, {obs[8], 8'h00}, {exp[8], 8'h00});
   endtask

   // Status read against a fixed expected value.
   task automatic checkStatus(input string tag, input logic [7:0] exp);
      logic [8:0] obs;
      applyStimulus(A_CTRL, 1'b1, 8'h00, obs);
      checkOutput(tag, obs, {1'b1, exp});
   endtask

   task automatic pushFrame(input logic [7:0] p0, input logic [7:0] p1);
      doWrite(A_DATA, p0);
      doWrite(A_DATA, p1);
   endtask

   task automatic strobe();
      doWrite(A_P0, 8'h01);
      doWrite(A_P0, 8'h00);
   endtask

   task automatic readBoth(input string tag, input int n);
      for (int i = 0; i < n; i++) doRead(A_P0, $sformatf("%s_p0_%0d", tag, i));
      for (int i = 0; i < n; i++) doRead(A_P1, $sformatf("%s_p1_%0d", tag, i));
   endtask

   // Directed scenarios, a random mix, then an asynchronous reset mid-shift.
   initial begin
      logic [8:0] obs;
      int         op;

      sys_rst  = 1'b1;
      cpu_addr = A_IDLE;
      cpu_rw   = 1'b1;
      cpu_dat  = 8'h00;
      modelReset();
      @(negedge m2);
      #2;
      sys_rst = 1'b0;

      $display("[TB] reset state");
      checkStatus("rst_status", 8'h00);
      applyStimulus(A_P0, 1'b1, 8'h00, obs);
      checkOutput("rst_pad", obs, 9'h041);
      doRead(A_P1, "rst_pad1");

      $display("[TB] basic serial order");
      doWrite(A_CTRL, 8'h80);
      pushFrame(8'hA5, 8'h3C);
      checkStatus("basic_status", 8'h81);
      strobe();
      readBoth("basic", 10);

      $display("[TB] strobe held");
      pushFrame(8'h5A, 8'hC3);
      doWrite(A_P0, 8'h01);
      for (int i = 0; i < 3; i++) doRead(A_P0, $sformatf("held_%0d", i));
      checkStatus("held_count", 8'h81);
      doWrite(A_P0, 8'h00);
      readBoth("held", 8);

      $display("[TB] underflow");
      doWrite(A_CTRL, 8'hC0);
      pushFrame(8'h01, 8'h02);
      strobe();
      readBoth("udf1", 8);
      strobe();
      readBoth("udf2", 8);
      checkStatus("udf_status", 8'hA0);

      $display("[TB] overflow and wrap");
      doWrite(A_CTRL, 8'hC0);
      for (int k = 0; k < 9; k++) pushFrame(8'(k), 8'(k + 16));
      checkStatus("ovf_status", 8'hC8);
      for (int k = 0; k < 8; k++) begin
         strobe();
         readBoth($sformatf("ovf%0d", k), 8);
      end
      checkStatus("ovf_drained", 8'hC0);
      for (int k = 0; k < 3; k++) pushFrame(8'($urandom), 8'($urandom));
      checkStatus("refill_status", 8'hC3);
      strobe();
      readBoth("refill", 9);

      $display("[TB] disable and flush");
      doWrite(A_CTRL, 8'h00);
      doRead(A_P0, "dis_pad");
      doRead(A_CTRL, "dis_status");
      doWrite(A_DATA, 8'h77);
      doWrite(A_CTRL, 8'hC0);
      checkStatus("flush_status", 8'h80);
      doWrite(A_DATA, 8'h11);
      checkStatus("phase_reset", 8'h80);
      doWrite(A_DATA, 8'h22);
      checkStatus("phase_push", 8'h81);

      $display("[TB] random mix");
      for (int n = 0; n < 600; n++) begin
         op = int'($urandom_range(0, 11));
         case (op)
            0, 1, 2: doWrite(A_DATA, 8'($urandom));
            3:       doWrite(A_CTRL, {($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                                      6'($urandom)});
            4, 5:    doWrite(A_P0, {7'($urandom), 1'($urandom)});
            6, 7:    doRead(A_P0, $sformatf("rnd_p0_%0d", n));
            8, 9:    doRead(A_P1, $sformatf("rnd_p1_%0d", n));
            10:      doRead(A_CTRL, $sformatf("rnd_ctrl_%0d", n));
            default: doRead(A_IDLE, $sformatf("rnd_idle_%0d", n));
         endcase
      end

      $display("[TB] async reset mid-shift");
      doWrite(A_CTRL, 8'hC0);
      pushFrame(8'h00, 8'h00);
      pushFrame(8'h96, 8'h69);
      strobe();
      for (int i = 0; i < 3; i++) doRead(A_P0, $sformatf("pre_rst_%0d", i));
      cpu_addr = A_CTRL;
      cpu_rw   = 1'b1;
      #2;
      sys_rst = 1'b1;
      #1;
      checkOutput("arst_status", {jtx_oe, jtx_do}, 9'h100);
      cpu_addr = A_P0;
      #2;
      checkOutput("arst_pad", {jtx_oe, jtx_do}, 9'h041);
      @(negedge m2);
      #2;
      sys_rst  = 1'b0;
      cpu_addr = A_IDLE;
      modelReset();
      checkStatus("post_rst_status", 8'h00);
      doWrite(A_CTRL, 8'h80);
      checkStatus("post_rst_empty", 8'h80);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(A_P0, 1'b1, 8'h00, obs);
         checkOutput($sformatf("post_rst_sr_%0d", i), obs, 9'h141);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/joy_tx.md
# joy_tx

Joypad transmitter for input playback. It is the controller-side counterpart of the joypad reader. When enabled, it answers CPU reads of $4016/$4017 with serial button bits taken from an 8-entry frame FIFO, which menu or PI software fills through two mapper registers. It sits beside the save-state controller on the shared CPU bus and follows the standard NES strobe/shift protocol.

## Interface
Parameters:
- REG_JTX_DATA, 16'h40F4, FIFO byte-write address.
- REG_JTX_CTRL, 16'h40F5, control write / status read address.
- FIFO_DEPTH, 8, frame entries (power of two).
- OPEN_BUS, 8'h40, value driven on bits [7:1] of pad reads.

Ports:
- sys_rst  in  1  reset; asynchronous, active-high.
- m2  in  1  CPU phase-2 clock; all state updates on negedge m2.
- cpu_addr  in  16  CPU address.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_dat  in  8  CPU data bus, sampled on writes.
- jtx_do  out  8  read data for pad and status reads.
- jtx_oe  out  1  asserted when jtx_do must drive the CPU bus.

## Operation
- **Frame entry.** 16 bits, {port1[7:0], port0[7:0]}. Bit 7 of each byte is serialized first (A, B, Sel, Start, Up, Dn, L, R).
- **Loading the FIFO.** Writes to REG_JTX_DATA alternate on a phase flag, reset to 0.
  - Phase 0 stores port0 into a staging byte.
  - Phase 1 pushes {cpu_dat, staging} as one entry.
  - A push while full is dropped and sets ovf. The phase flag still toggles.
- **REG_JTX_CTRL write.**
  - bit7 sets en.
  - bit6 = 1 flushes the FIFO, resets the phase flag, and clears ovf/udf. This bit is self-clearing.
- **REG_JTX_CTRL read.** Returns {en, ovf, udf, 1'b0, count[3:0]}, with count 0..8. jtx_oe = 1 for this read.
- **Strobe.** A write to $4016 sets load <= cpu_dat[0].
  - On a 1→0 transition of load:
    - If the FIFO is not empty, pop the head and copy it to hold_frame.
    - If the FIFO is empty, hold_frame is unchanged and udf is set.
    - Both shift registers are loaded from hold_frame.
  - A 0→0 or 1→1 write does not pop.
- **Pad read, $4016 → port0 shift register, $4017 → port1.**
  - While load = 1: bit0 = head[7] of the port, or hold_frame[7] if the FIFO is empty. No shift.
  - While load = 0: bit0 = sr[7]; then sr <= {sr[6:0], 1'b1}.
  - After 8 reads every further read returns 1.
- **Output data.** jtx_do = {OPEN_BUS[7:1], bit}.
- **Disabled.** When en = 0:
  - Pad reads are not driven: jtx_oe = 0.
  - The shift registers still track the strobe, but no pop occurs and udf is never set.
  - Register accesses still work.
- **Output enable.** jtx_oe = cpu_rw & ((en & pad addr) | ctrl addr). It is combinational; jtx_do is combinational from state.

## Timing
- **Reset values.** Asserting sys_rst clears, asynchronously:
  - FIFO pointers, count = 0, phase = 0.
  - en = 0, ovf = 0, udf = 0, load = 0.
  - hold_frame = 16'hFFFF, sr0 = sr1 = 8'hFF.
  - Output result: jtx_do = 8'h41 on a pad address and jtx_oe = 0.
- **Pad read timing.** Read data for cycle N reflects state after negedge m2 of cycle N-1. The shift happens at negedge m2 ending the read, so consecutive reads return consecutive bits.
- **Push latency.** A pushed entry is visible as head[7] on the very next cycle. It is consumed at the next strobe fall.
- **Simultaneous push and pop on one edge.** This is impossible on a single CPU bus but must be defined: count is unchanged and both pointers advance.
- **Pop with a push of full.** A pop on a full FIFO in the same edge as a phase-1 push accepts the push, and no ovf is set.
- **Flush versus strobe fall.** A flush in the same cycle as a strobe fall wins: no pop occurs and udf is not set.
- **Pointer wrap.** Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is the separate 4-bit value.
- **Reset mid-frame.** This abandons the shift and discards FIFO contents.

## Test plan
- **Basic serial order.**
  - Stimulus: write ctrl=$80, data $A5, then $3C; strobe 1,0; read $4016 ×10 and $4017 ×10.
  - Required response: port0 bits 1,0,1,0,0,1,0,1,1,1; port1 bits 0,0,1,1,1,1,0,0,1,1; each read returns $40|bit with jtx_oe = 1.
- **Strobe held.**
  - Stimulus: load = 1, then read $4016 ×3.
  - Required response: all three reads return head bit7; count is unchanged.
- **Underflow.**
  - Stimulus: push one frame $01/$02, strobe twice.
  - Required response: the second pass repeats $01/$02; status = $A0 (en, udf, count 0).
- **Overflow and wrap.**
  - Stimulus: push 9 frames $00..$08.
  - Required response: status = $C8; subsequent strobes return $00..$07 in order, and the pointers wrap correctly on a refill.
- **Disable and flush.**
  - Stimulus: en = 0, then read $4016.
  - Required response: jtx_oe = 0.
  - Stimulus: write ctrl=$C0.
  - Required response: status = $80 and phase = 0, so the next single data write does not push.
- **Async reset.**
  - Stimulus: assert sys_rst mid-shift after 3 reads.
  - Required response: status = $00, sr = $FF, and the FIFO is empty.
